// File: rtl/iob_cfg_loader.sv
// iob_cfg_loader
// Serial configuration loader for a column of NIOB I/O blocks. A framed bit
// stream (8-bit sync header MSB first, 3*NIOB payload bits LSB first, one even
// parity bit) is captured into a shadow register. Only a frame with a matching
// header and correct parity is committed to the live outputs, all at once.
//
// Ports
//   IOCLK       clock, all state updates on the rising edge
//   RST         asynchronous active-high reset
//   CFG_START   one-cycle pulse: begin a frame (aborts any frame in progress)
//   CFG_VALID   CFG_DIN carries a frame bit this cycle
//   CFG_DIN     serial frame data
//   TSMUX_OUT   block j tri-state mode in [2j+1:2j] (00 hi-Z, 01 TS-gated, 1x drive)
//   DORREG_OUT  block j input select (0 direct pin, 1 registered)
//   CFG_BUSY    a frame is in progress
//   CFG_DONE    one-cycle pulse on a successful commit
//   CFG_ERR     sticky error flag, cleared by CFG_START or RST
//   DBG_STATE   current FSM state (0 IDLE, 1 HDR, 2 PAY, 3 PAR)
//
// Handshake: CFG_VALID qualifies CFG_DIN with no backpressure; every cycle with
// CFG_VALID high in HDR/PAY/PAR consumes exactly one frame bit, and cycles with
// CFG_VALID low hold all state. CFG_START has priority over CFG_VALID, and
// CFG_DIN in the start cycle is never a frame bit.
module iob_cfg_loader #(
  parameter int         NIOB = 8,
  parameter logic [7:0] SYNC = 8'hA5
) (
  input  logic                IOCLK,
  input  logic                RST,
  input  logic                CFG_START,
  input  logic                CFG_VALID,
  input  logic                CFG_DIN,
  output logic [2*NIOB-1:0]   TSMUX_OUT,
  output logic [NIOB-1:0]     DORREG_OUT,
  output logic                CFG_BUSY,
  output logic                CFG_DONE,
  output logic                CFG_ERR,
  output logic [1:0]          DBG_STATE
);

  localparam int PW  = 3 * NIOB;
  localparam int CW0 = $clog2(PW + 1);
  // At least 3 bits so the 8-bit header count still fits for tiny NIOB.
  localparam int CW  = (CW0 < 3) ? 3 : CW0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    PAR  = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [7:0]      hdr_sr;
  logic [PW-1:0]   payload;
  logic            par_acc;
  logic [7:0]      hdr_next;

  // Header value including the bit arriving this cycle, so the compare can
  // happen on the same edge that takes the 8th header bit.
  always_comb begin
    hdr_next = {hdr_sr[6:0], CFG_DIN};
  end

  assign DBG_STATE = state;

  always_ff @(posedge IOCLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      hdr_sr     <= '0;
      payload    <= '0;
      par_acc    <= 1'b0;
      TSMUX_OUT  <= '0;
      DORREG_OUT <= '0;
      CFG_BUSY   <= 1'b0;
      CFG_DONE   <= 1'b0;
      CFG_ERR    <= 1'b0;
    end else begin
      CFG_DONE <= 1'b0;
      if (CFG_START) begin
        // Start or restart: the live outputs are left alone until a full,
        // clean frame arrives.
        state    <= HDR;
        cnt      <= '0;
        hdr_sr   <= '0;
        payload  <= '0;
        par_acc  <= 1'b0;
        CFG_ERR  <= 1'b0;
        CFG_BUSY <= 1'b1;
      end else if (CFG_VALID) begin
        case (state)
          IDLE: ;
          HDR: begin
            hdr_sr <= hdr_next;
            if (cnt == CW'(7)) begin
              cnt <= '0;
              if (hdr_next == SYNC) begin
                state <= PAY;
              end else begin
                state    <= IDLE;
                CFG_ERR  <= 1'b1;
                CFG_BUSY <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PAY: begin
            payload[cnt] <= CFG_DIN;
            par_acc      <= par_acc ^ CFG_DIN;
            if (cnt == CW'(PW - 1)) begin
              cnt   <= '0;
              state <= PAR;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PAR: begin
            if ((par_acc ^ CFG_DIN) == 1'b0) begin
              for (int j = 0; j < NIOB; j++) begin
                TSMUX_OUT[2*j +: 2] <= payload[3*j +: 2];
                DORREG_OUT[j]       <= payload[3*j + 2];
              end
              CFG_DONE <= 1'b1;
            end else begin
              CFG_ERR <= 1'b1;
            end
            cnt      <= '0;
            state    <= IDLE;
            CFG_BUSY <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iob_cfg_loader.sv
module tb_iob_cfg_loader;

  localparam int NIOB = 8;
  localparam int PW   = 3 * NIOB;

  logic              IOCLK;
  logic              RST;
  logic              CFG_START;
  logic              CFG_VALID;
  logic              CFG_DIN;
  logic [2*NIOB-1:0] TSMUX_OUT;
  logic [NIOB-1:0]   DORREG_OUT;
  logic              CFG_BUSY;
  logic              CFG_DONE;
  logic              CFG_ERR;
  logic [1:0]        DBG_STATE;

  iob_cfg_loader #(.NIOB(NIOB), .SYNC(8'hA5)) dut (
    .IOCLK      (IOCLK),
    .RST        (RST),
    .CFG_START  (CFG_START),
    .CFG_VALID  (CFG_VALID),
    .CFG_DIN    (CFG_DIN),
    .TSMUX_OUT  (TSMUX_OUT),
    .DORREG_OUT (DORREG_OUT),
    .CFG_BUSY   (CFG_BUSY),
    .CFG_DONE   (CFG_DONE),
    .CFG_ERR    (CFG_ERR),
    .DBG_STATE  (DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  initial IOCLK = 1'b0;
  always #5 IOCLK = ~IOCLK;

  int total = 0;
  int bad   = 0;

  // Scoreboard: {TSMUX_OUT, DORREG_OUT} expected at each CFG_DONE pulse.
  logic [3*NIOB-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference mapping from a payload to the committed outputs.
  function automatic logic [3*NIOB-1:0] cfg_map(input logic [PW-1:0] p);
    logic [2*NIOB-1:0] ts;
    logic [NIOB-1:0]   dr;
    for (int j = 0; j < NIOB; j++) begin
      ts[2*j]   = p[3*j];
      ts[2*j+1] = p[3*j+1];
      dr[j]     = p[3*j+2];
    end
    return {ts, dr};
  endfunction

  always @(negedge IOCLK) begin
    if (!RST && CFG_DONE) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done: got ts=%h dr=%h want no done", TSMUX_OUT, DORREG_OUT);
      end else begin
        logic [3*NIOB-1:0] e;
        e = exp_q.pop_front();
        if ({TSMUX_OUT, DORREG_OUT} !== e) begin
          bad++;
          $display("FAIL sb_commit: got %h want %h", {TSMUX_OUT, DORREG_OUT}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One clock cycle: drive at the falling edge, return just after the rising
  // edge so the caller sees outputs resulting from this cycle's inputs.
  task automatic cyc(input logic s, input logic v, input logic d);
    @(negedge IOCLK);
    CFG_START = s;
    CFG_VALID = v;
    CFG_DIN   = d;
    @(posedge IOCLK);
    #1;
  endtask

  task automatic send_bit(input logic d, input bit gaps);
    if (gaps) begin
      int n;
      n = $urandom_range(0, 5);
      for (int g = 0; g < n; g++) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
    cyc(1'b0, 1'b1, d);
  endtask

  // Sends a whole frame; returns right after the parity bit's edge.
  task automatic send_frame(input logic [7:0] hdr, input logic [PW-1:0] p,
                            input bit flip, input bit gaps);
    cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    chk("busy_after_start", 32'(CFG_BUSY), 32'd1);
    for (int i = 7; i >= 0; i--) send_bit(hdr[i], gaps);
    if (hdr != 8'hA5) begin
      chk("hdr_err_rise", 32'(CFG_ERR), 32'd1);
      chk("hdr_err_idle", 32'(DBG_STATE), 32'd0);
    end
    for (int k = 0; k < PW; k++) send_bit(p[k], gaps);
    if (hdr == 8'hA5 && !flip) exp_q.push_back(cfg_map(p));
    send_bit((^p) ^ flip, gaps);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]        hdr;
    logic [PW-1:0]     payload;
    bit                flip;
    bit                gaps;
    logic [2*NIOB-1:0] exp_ts;
    logic [NIOB-1:0]   exp_dr;
    logic              exp_done;
    logic              exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'hA5, 24'h400005, 0, 0, 16'h8001, 8'h01, 1'b1, 1'b0}; // good frame
    vecs[1] = '{8'hA4, 24'h400005, 0, 0, 16'h8001, 8'h01, 1'b0, 1'b1}; // bad header
    vecs[2] = '{8'hA5, 24'h000000, 1, 0, 16'h8001, 8'h01, 1'b0, 1'b1}; // bad parity
    vecs[3] = '{8'hA5, 24'h249249, 0, 0, 16'h5555, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'hA5, 24'h924924, 0, 0, 16'h0000, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'hA5, 24'h400005, 0, 1, 16'h8001, 8'h01, 1'b1, 1'b0}; // stalls
    vecs[6] = '{8'hA5, 24'h000000, 0, 0, 16'h0000, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'hA5, 24'h492492, 0, 1, 16'hAAAA, 8'h00, 1'b1, 1'b0};
  end

  // ---------------- test sequence ----------------
  initial begin
    RST = 1'b1;
    CFG_START = 1'b0;
    CFG_VALID = 1'b0;
    CFG_DIN = 1'b0;
    repeat (3) @(posedge IOCLK);
    #1;
    chk("rst_ts", 32'(TSMUX_OUT), 32'd0);
    chk("rst_dr", 32'(DORREG_OUT), 32'd0);
    chk("rst_busy", 32'(CFG_BUSY), 32'd0);
    chk("rst_done", 32'(CFG_DONE), 32'd0);
    chk("rst_err", 32'(CFG_ERR), 32'd0);
    chk("rst_state", 32'(DBG_STATE), 32'd0);
    @(negedge IOCLK);
    RST = 1'b0;

    // Valid bits without a start are ignored.
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("nostart_busy", 32'(CFG_BUSY), 32'd0);
    chk("nostart_ts", 32'(TSMUX_OUT), 32'd0);

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].hdr, vecs[i].payload, vecs[i].flip, vecs[i].gaps);
      chk($sformatf("v%0d_done", i), 32'(CFG_DONE), 32'(vecs[i].exp_done));
      chk($sformatf("v%0d_err", i), 32'(CFG_ERR), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_ts", i), 32'(TSMUX_OUT), 32'(vecs[i].exp_ts));
      chk($sformatf("v%0d_dr", i), 32'(DORREG_OUT), 32'(vecs[i].exp_dr));
      chk($sformatf("v%0d_busy", i), 32'(CFG_BUSY), 32'd0);
      cyc(1'b0, 1'b0, 1'b0);
      chk($sformatf("v%0d_done_off", i), 32'(CFG_DONE), 32'd0);
    end

    // Restart after 20 payload bits, then a full all-ones frame.
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) cyc(1'b0, 1'b1, 1'((8'hA5 >> i) & 1));
    for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1, 1'b0);
    chk("restart_hold_ts", 32'(TSMUX_OUT), 32'h0000AAAA);
    chk("restart_state", 32'(DBG_STATE), 32'd2);
    send_frame(8'hA5, 24'hFFFFFF, 0, 0);
    chk("restart_done", 32'(CFG_DONE), 32'd1);
    chk("restart_ts", 32'(TSMUX_OUT), 32'h0000FFFF);
    chk("restart_dr", 32'(DORREG_OUT), 32'h000000FF);

    // Back-to-back: start in the cycle CFG_DONE is high.
    send_frame(8'hA5, 24'h249249, 0, 0);
    chk("b2b_done", 32'(CFG_DONE), 32'd1);
    send_frame(8'hA5, 24'hFFFFFF, 0, 0);
    chk("b2b_ts", 32'(TSMUX_OUT), 32'h0000FFFF);

    // Asynchronous reset mid-frame with nonzero committed outputs.
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_ts", 32'(TSMUX_OUT), 32'd0);
    chk("arst_dr", 32'(DORREG_OUT), 32'd0);
    chk("arst_busy", 32'(CFG_BUSY), 32'd0);
    chk("arst_state", 32'(DBG_STATE), 32'd0);
    @(negedge IOCLK);
    RST = 1'b0;
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("post_rst_busy", 32'(CFG_BUSY), 32'd0);
    chk("post_rst_ts", 32'(TSMUX_OUT), 32'd0);
    chk("post_rst_done_cnt", 32'(CFG_DONE), 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
